// File: rtl/sent_tx_serial_sched.sv
// SENT slow-channel scheduler: buffers one serial message, computes its CRC
// bit-serially, then drives the status-nibble bit2/bit3 values frame by frame.
module sent_tx_serial_sched #(
    parameter int SHORT_FRAMES = 16,
    parameter int ENH_FRAMES   = 18
) (
    input  logic        clk_tx,
    input  logic        reset_n_tx,
    input  logic [1:0]  mode_i,
    input  logic        config_bit_i,
    input  logic [7:0]  id_i,
    input  logic [15:0] data_i,
    input  logic        msg_valid_i,
    output logic        msg_ready_o,
    input  logic        abort_i,
    input  logic        frame_start_i,
    output logic        bit2_o,
    output logic        bit3_o,
    output logic [4:0]  frame_idx_o,
    output logic        busy_o,
    output logic        msg_done_o
);

    localparam logic [1:0] MODE_SHORT = 2'b01;
    localparam logic [1:0] MODE_ENH   = 2'b10;
    localparam logic [4:0] SHORT_LAST = 5'(SHORT_FRAMES - 1);
    localparam logic [4:0] ENH_LAST   = 5'(ENH_FRAMES - 1);
    localparam logic [3:0] CRC4_SEED  = 4'b0101;
    localparam logic [3:0] CRC4_POLY  = 4'b1101;
    localparam logic [5:0] CRC6_SEED  = 6'b010101;
    localparam logic [5:0] CRC6_POLY  = 6'b011001;
    localparam logic [4:0] CRC4_LAST  = 5'd15;
    localparam logic [4:0] CRC6_LAST  = 5'd29;

    typedef enum logic {IDLE, SEND} state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [4:0]  r_idx;
    logic        r_bit2;
    logic        r_bit3;
    logic        r_done;
    logic        r_readyEn;

    logic [1:0]  r_actMode;
    logic        r_actCfg;
    logic [7:0]  r_actId;
    logic [15:0] r_actData;
    logic [5:0]  r_actCrc;

    logic        r_pendValid;
    logic        r_pendRdy;
    logic        r_crcRun;
    logic [4:0]  r_crcCnt;
    logic [5:0]  r_crc;
    logic [1:0]  r_pendMode;
    logic        r_pendCfg;
    logic [7:0]  r_pendId;
    logic [15:0] r_pendData;

    logic        w_accept;
    logic [4:0]  w_lastIdx;
    logic        w_advance;
    logic        w_finish;
    logic        w_loadRule;
    logic        w_load;
    logic        w_crcIn;
    logic [5:0]  w_crcNext;
    logic [1:0]  w_nextBits;
    logic [4:0]  w_nextIdx;
    logic        w_nextDone;

    // Returns {bit3, bit2} for one frame of a message; crc is ignored where unused.
    function automatic logic [1:0] frameBits(
        input logic [1:0]  mode,
        input logic        cfg,
        input logic [7:0]  id,
        input logic [15:0] data,
        input logic [5:0]  crc,
        input logic [4:0]  idx
    );
        logic b2;
        logic b3;
        b2 = 1'b0;
        b3 = 1'b0;
        if (mode == MODE_SHORT) begin
            b3 = (idx == 5'd0);
            if (idx < 5'd4)
                b2 = id[3'(3 - int'(idx))];
            else if (idx < 5'd12)
                b2 = data[4'(11 - int'(idx))];
            else if (idx < 5'd16)
                b2 = crc[3'(15 - int'(idx))];
        end else begin
            if (idx < 5'd6) begin
                b3 = 1'b1;
                b2 = crc[3'(5 - int'(idx))];
            end else if (idx < 5'd18) begin
                b2 = data[4'(17 - int'(idx))];
                if (idx == 5'd7)
                    b3 = cfg;
                else if (idx >= 5'd8 && idx <= 5'd11)
                    b3 = cfg ? id[3'(11 - int'(idx))] : id[3'(15 - int'(idx))];
                else if (idx >= 5'd13 && idx <= 5'd16)
                    b3 = cfg ? data[4'(28 - int'(idx))] : id[3'(16 - int'(idx))];
            end
        end
        return {b3, b2};
    endfunction

    // Serial CRC input stream: short uses the bit2 payload, enhanced the bit2/bit3 pairs of frames 6..17.
    function automatic logic crcInBit(
        input logic [1:0]  mode,
        input logic        cfg,
        input logic [7:0]  id,
        input logic [15:0] data,
        input logic [4:0]  cnt
    );
        logic [1:0] bits;
        logic       b;
        b = 1'b0;
        if (mode == MODE_SHORT) begin
            bits = frameBits(mode, cfg, id, data, 6'd0, cnt);
            if (cnt < 5'd12)
                b = bits[0];
        end else begin
            bits = frameBits(mode, cfg, id, data, 6'd0, 5'd6 + {1'b0, cnt[4:1]});
            if (cnt < 5'd24)
                b = cnt[0] ? bits[1] : bits[0];
        end
        return b;
    endfunction

    assign w_accept    = msg_valid_i && msg_ready_o && !abort_i;
    assign msg_ready_o = r_readyEn && !r_pendValid && (mode_i == MODE_SHORT || mode_i == MODE_ENH);
    assign busy_o      = (r_state == SEND) || r_pendValid;
    assign bit2_o      = r_bit2;
    assign bit3_o      = r_bit3;
    assign frame_idx_o = r_idx;
    assign msg_done_o  = r_done;

    assign w_lastIdx  = (r_actMode == MODE_ENH) ? ENH_LAST : SHORT_LAST;
    assign w_advance  = frame_start_i && !abort_i && (r_state == SEND) && (r_idx < w_lastIdx);
    assign w_finish   = frame_start_i && !abort_i && (r_state == SEND) && (r_idx == w_lastIdx);
    assign w_loadRule = frame_start_i && !abort_i && !w_advance;
    assign w_load     = w_loadRule && r_pendRdy;

    // One LFSR step of the pending message's CRC, width chosen by its mode.
    always_comb begin
        w_crcIn   = crcInBit(r_pendMode, r_pendCfg, r_pendId, r_pendData, r_crcCnt);
        w_crcNext = 6'd0;
        if (r_pendMode == MODE_SHORT)
            w_crcNext = {2'b00, r_crc[2:0], w_crcIn} ^ (r_crc[3] ? {2'b00, CRC4_POLY} : 6'd0);
        else
            w_crcNext = {r_crc[4:0], w_crcIn} ^ (r_crc[5] ? CRC6_POLY : 6'd0);
    end

    // State register.
    always_ff @(posedge clk_tx or negedge reset_n_tx) begin
        if (!reset_n_tx)
            r_state <= IDLE;
        else
            r_state <= w_nextState;
    end

    // Next-state decision on each frame pulse; abort always wins.
    always_comb begin
        w_nextState = r_state;
        if (abort_i)
            w_nextState = IDLE;
        else if (w_advance)
            w_nextState = SEND;
        else if (w_loadRule)
            w_nextState = r_pendRdy ? SEND : IDLE;
    end

    // Next bits/index/done values presented after a frame pulse.
    always_comb begin
        w_nextBits = {r_bit3, r_bit2};
        w_nextIdx  = r_idx;
        w_nextDone = 1'b0;
        if (abort_i) begin
            w_nextBits = 2'b00;
            w_nextIdx  = 5'd0;
        end else if (w_advance) begin
            w_nextIdx  = r_idx + 5'd1;
            w_nextBits = frameBits(r_actMode, r_actCfg, r_actId, r_actData, r_actCrc, r_idx + 5'd1);
        end else if (w_loadRule) begin
            w_nextDone = w_finish;
            w_nextIdx  = 5'd0;
            w_nextBits = r_pendRdy ? frameBits(r_pendMode, r_pendCfg, r_pendId, r_pendData, r_crc, 5'd0)
                                   : 2'b00;
        end
    end

    // Registered outputs and the active message slot.
    always_ff @(posedge clk_tx or negedge reset_n_tx) begin
        if (!reset_n_tx) begin
            r_idx     <= 5'd0;
            r_bit2    <= 1'b0;
            r_bit3    <= 1'b0;
            r_done    <= 1'b0;
            r_readyEn <= 1'b0;
            r_actMode <= 2'b00;
            r_actCfg  <= 1'b0;
            r_actId   <= 8'd0;
            r_actData <= 16'd0;
            r_actCrc  <= 6'd0;
        end else begin
            r_readyEn <= 1'b1;
            r_idx     <= w_nextIdx;
            r_bit3    <= w_nextBits[1];
            r_bit2    <= w_nextBits[0];
            r_done    <= w_nextDone;
            if (w_load) begin
                r_actMode <= r_pendMode;
                r_actCfg  <= r_pendCfg;
                r_actId   <= r_pendId;
                r_actData <= r_pendData;
                r_actCrc  <= r_crc;
            end
        end
    end

    // Pending slot: capture on accept, run the CRC, free when moved to active.
    always_ff @(posedge clk_tx or negedge reset_n_tx) begin
        if (!reset_n_tx) begin
            r_pendValid <= 1'b0;
            r_pendRdy   <= 1'b0;
            r_crcRun    <= 1'b0;
            r_crcCnt    <= 5'd0;
            r_crc       <= 6'd0;
            r_pendMode  <= 2'b00;
            r_pendCfg   <= 1'b0;
            r_pendId    <= 8'd0;
            r_pendData  <= 16'd0;
        end else if (abort_i) begin
            r_pendValid <= 1'b0;
            r_pendRdy   <= 1'b0;
            r_crcRun    <= 1'b0;
        end else begin
            if (w_load) begin
                r_pendValid <= 1'b0;
                r_pendRdy   <= 1'b0;
            end
            if (w_accept) begin
                r_pendValid <= 1'b1;
                r_pendRdy   <= 1'b0;
                r_crcRun    <= 1'b1;
                r_crcCnt    <= 5'd0;
                r_crc       <= (mode_i == MODE_SHORT) ? {2'b00, CRC4_SEED} : CRC6_SEED;
                r_pendMode  <= mode_i;
                r_pendCfg   <= config_bit_i;
                r_pendId    <= id_i;
                r_pendData  <= data_i;
            end else if (r_crcRun) begin
                r_crc    <= w_crcNext;
                r_crcCnt <= r_crcCnt + 5'd1;
                if (r_crcCnt == ((r_pendMode == MODE_SHORT) ? CRC4_LAST : CRC6_LAST)) begin
                    r_crcRun  <= 1'b0;
                    r_pendRdy <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sent_tx_serial_sched.sv
// Directed bench for the SENT slow-channel scheduler.
module tb_sent_tx_serial_sched;

    logic        clk_tx = 1'b0;
    logic        reset_n_tx = 1'b0;
    logic [1:0]  mode_i = 2'b01;
    logic        config_bit_i = 1'b0;
    logic [7:0]  id_i = 8'd0;
    logic [15:0] data_i = 16'd0;
    logic        msg_valid_i = 1'b0;
    logic        msg_ready_o;
    logic        abort_i = 1'b0;
    logic        frame_start_i = 1'b0;
    logic        bit2_o;
    logic        bit3_o;
    logic [4:0]  frame_idx_o;
    logic        busy_o;
    logic        msg_done_o;

    int total = 0;
    int bad = 0;
    int doneCount = 0;

    typedef struct {
        logic [1:0]  mode;
        logic        cfg;
        logic [7:0]  id;
        logic [15:0] data;
        int          nfr;
        logic [17:0] expB3;
        logic [17:0] expB2;
    } vec_t;

    vec_t vecs[3];

    sent_tx_serial_sched dut (
        .clk_tx        (clk_tx),
        .reset_n_tx    (reset_n_tx),
        .mode_i        (mode_i),
        .config_bit_i  (config_bit_i),
        .id_i          (id_i),
        .data_i        (data_i),
        .msg_valid_i   (msg_valid_i),
        .msg_ready_o   (msg_ready_o),
        .abort_i       (abort_i),
        .frame_start_i (frame_start_i),
        .bit2_o        (bit2_o),
        .bit3_o        (bit3_o),
        .frame_idx_o   (frame_idx_o),
        .busy_o        (busy_o),
        .msg_done_o    (msg_done_o)
    );

    // Free-running transmitter clock.
    always #5 clk_tx = ~clk_tx;

    // Counts completed-message pulses.
    always @(negedge clk_tx) if (msg_done_o) doneCount++;

    // Reference CRC by polynomial long division of {seed, input bits}.
    function automatic logic [5:0] crcModel(input int width, input logic [6:0] polyFull,
                                            input logic [5:0] seed, input logic [63:0] bits, input int n);
        logic [63:0] d;
        d = (64'(seed) << n) | bits;
        for (int i = width + n - 1; i >= width; i--)
            if (d[i]) d = d ^ (64'(polyFull) << (i - width));
        return d[5:0];
    endfunction

    function automatic logic [3:0] shortCrc(input logic [3:0] id, input logic [7:0] data);
        return 4'(crcModel(4, 7'b0011101, 6'b000101, 64'({id, data, 4'b0000}), 16));
    endfunction

    function automatic logic [5:0] enhCrc(input logic [17:0] b3, input logic [11:0] data12);
        logic [63:0] b;
        b = 64'd0;
        for (int k = 0; k < 12; k++)
            b = (b << 2) | 64'({data12[11 - k], b3[11 - k]});
        b = b << 6;
        return crcModel(6, 7'b1011001, 6'b010101, b, 30);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk_tx);
    endtask

    task automatic pulseFrame();
        frame_start_i = 1'b1;
        @(negedge clk_tx);
        frame_start_i = 1'b0;
    endtask

    task automatic sendMsg(input logic [1:0] mode, input logic cfg, input logic [7:0] id, input logic [15:0] data);
        int guard;
        guard = 0;
        mode_i = mode;
        config_bit_i = cfg;
        id_i = id;
        data_i = data;
        @(negedge clk_tx);
        while (!msg_ready_o && guard < 200) begin
            @(negedge clk_tx);
            guard++;
        end
        if (!msg_ready_o) begin
            total++;
            bad++;
            $display("[TB] FAIL readyTimeout: got 0 want 1");
        end
        msg_valid_i = 1'b1;
        @(negedge clk_tx);
        msg_valid_i = 1'b0;
    endtask

    function automatic logic [31:0] frameState();
        return {25'd0, bit3_o, bit2_o, frame_idx_o};
    endfunction

    function automatic logic [31:0] expFrame(input vec_t v, input int f);
        return {25'd0, v.expB3[v.nfr - 1 - f], v.expB2[v.nfr - 1 - f], 5'(f)};
    endfunction

    task automatic applyStimulus(input int k, input vec_t v);
        int base;
        int gap;
        gap = (v.nfr == 16) ? 48 : 18;
        sendMsg(v.mode, v.cfg, v.id, v.data);
        waitCycles(40);
        base = doneCount;
        for (int f = 0; f < v.nfr; f++) begin
            pulseFrame();
            checkOutput($sformatf("vec%0d frame%0d", k, f), frameState(), expFrame(v, f));
            waitCycles(gap);
        end
        checkOutput($sformatf("vec%0d earlyDone", k), 32'(doneCount - base), 32'd0);
        pulseFrame();
        waitCycles(1);
        checkOutput($sformatf("vec%0d done", k), 32'(doneCount - base), 32'd1);
        checkOutput($sformatf("vec%0d idleAfter", k), {busy_o, frameState()[6:0]}, 32'd0);
    endtask

    initial begin
        int base;
        vec_t msgB;

        vecs[0] = '{2'b01, 1'b0, 8'h05, 16'h00A3, 16, 18'h08000, 18'h05A3C};
        vecs[1] = '{2'b10, 1'b0, 8'h3C, 16'h00F5, 18, 18'b111111000011011000, 18'h0};
        vecs[1].expB2 = {enhCrc(vecs[1].expB3, 12'h0F5), 12'h0F5};
        vecs[2] = '{2'b10, 1'b1, 8'h09, 16'hB0F5, 18, 18'b111111011001010110, 18'h0};
        vecs[2].expB2 = {enhCrc(vecs[2].expB3, 12'h0F5), 12'h0F5};
        msgB = '{2'b01, 1'b0, 8'h0A, 16'h003C, 16, 18'h08000, 18'h0};
        msgB.expB2 = {2'b00, 4'hA, 8'h3C, shortCrc(4'hA, 8'h3C)};

        // Reset state
        waitCycles(3);
        checkOutput("resetOutputs", {msg_ready_o, busy_o, msg_done_o, frameState()[6:0]}, 32'd0);
        reset_n_tx = 1'b1;
        waitCycles(2);
        checkOutput("readyAfterReset", {msg_ready_o, busy_o}, 32'b10);

        // Table-driven whole messages
        for (int k = 0; k < 3; k++)
            applyStimulus(k, vecs[k]);

        // Asynchronous reset in the middle of frame 7
        sendMsg(2'b01, 1'b0, 8'h05, 16'h00A3);
        waitCycles(40);
        for (int f = 0; f < 8; f++) begin
            pulseFrame();
            waitCycles(4);
        end
        checkOutput("preResetFrame7", {busy_o, frameState()[6:0]}, {24'd0, 1'b1, expFrame(vecs[0], 7)[6:0]});
        #2 reset_n_tx = 1'b0;
        #1 checkOutput("midSendReset", {msg_ready_o, busy_o, msg_done_o, frameState()[6:0]}, 32'd0);
        @(negedge clk_tx);
        reset_n_tx = 1'b1;
        waitCycles(2);
        checkOutput("readyAfterMidReset", {msg_ready_o, busy_o}, 32'b10);

        // Back-to-back messages with no gap frame
        sendMsg(2'b01, 1'b0, 8'h05, 16'h00A3);
        waitCycles(40);
        base = doneCount;
        for (int f = 0; f < 16; f++) begin
            pulseFrame();
            checkOutput($sformatf("b2bA frame%0d", f), frameState(), expFrame(vecs[0], f));
            if (f == 3) sendMsg(2'b01, 1'b0, 8'h0A, 16'h003C);
            waitCycles(30);
        end
        for (int f = 0; f < 16; f++) begin
            pulseFrame();
            checkOutput($sformatf("b2bB frame%0d", f), frameState(), expFrame(msgB, f));
            if (f == 0) begin
                waitCycles(1);
                checkOutput("b2bFirstDone", 32'(doneCount - base), 32'd1);
                checkOutput("b2bReadyBack", {31'd0, msg_ready_o}, 32'd1);
            end
            waitCycles(10);
        end
        pulseFrame();
        waitCycles(1);
        checkOutput("b2bTotalDone", 32'(doneCount - base), 32'd2);
        checkOutput("b2bIdle", {busy_o, frameState()[6:0]}, 32'd0);

        // Frame pulse while the CRC is still running, then abort at frame 10
        sendMsg(2'b10, 1'b0, 8'h3C, 16'h00F5);
        waitCycles(3);
        pulseFrame();
        checkOutput("crcBusyFrame", {busy_o, frameState()[6:0]}, 32'h80);
        waitCycles(30);
        base = doneCount;
        for (int f = 0; f < 11; f++) begin
            pulseFrame();
            checkOutput($sformatf("late frame%0d", f), frameState(), expFrame(vecs[1], f));
            waitCycles(5);
        end
        msg_valid_i = 1'b1;
        abort_i = 1'b1;
        @(negedge clk_tx);
        msg_valid_i = 1'b0;
        abort_i = 1'b0;
        checkOutput("abortOutputs", {msg_ready_o, busy_o, msg_done_o, frameState()[6:0]}, 32'h200);
        waitCycles(40);
        pulseFrame();
        waitCycles(1);
        checkOutput("abortNoDone", 32'(doneCount - base), 32'd0);
        checkOutput("abortAcceptDropped", {busy_o, frameState()[6:0]}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sent_tx_serial_sched.md
Name: sent_tx_serial_sched

Overview:
- Slow-channel (serial message) scheduler for the SENT transmitter.
- Accepts a serial message (ID, data, format) through a valid/ready handshake and computes its serial CRC internally.
- On each frame-start pulse from the TX control block, presents the status-nibble bit2/bit3 values for the current frame, across the 16-frame (short) or 18-frame (enhanced) serial sequence.
- A one-entry pending buffer allows back-to-back messages with no gap frames.

Parameters:
- SHORT_FRAMES, 16, frames per short serial message
- ENH_FRAMES, 18, frames per enhanced serial message

Ports:
- clk_tx  input  1  transmitter clock
- reset_n_tx  input  1  asynchronous active-low reset
- mode_i  input  2  01 short serial, 10 enhanced; 00/11 invalid
- config_bit_i  input  1  enhanced C bit: 0 = 8-bit ID/12-bit data, 1 = 4-bit ID/16-bit data
- id_i  input  8  message ID
- data_i  input  16  message data
- msg_valid_i  input  1  message offered
- msg_ready_o  output  1  pending slot free and mode_i valid
- abort_i  input  1  synchronous flush
- frame_start_i  input  1  one-cycle pulse per SENT frame, from control block
- bit2_o  output  1  status nibble bit 2 for current frame
- bit3_o  output  1  status nibble bit 3 for current frame
- frame_idx_o  output  5  frame index within active message
- busy_o  output  1  active or pending message present
- msg_done_o  output  1  one-cycle pulse when a message's last frame completes

Behaviour:
- Reset: all outputs 0. Active and pending slots empty. State IDLE.
- Accept:
  - Transfer occurs when msg_valid_i && msg_ready_o.
  - mode_i, config_bit_i, id_i and data_i are latched into the pending slot.
  - msg_ready_o drops the next cycle.
- CRC engine: runs on the pending slot only, starting the cycle after accept.
  - Short: CRC-4, poly x^4+x^3+x^2+1, seed 0101. Input bits MSB first are ID[3:0], data[7:0], then 4 zero augmentation bits. 16 cycles.
  - Enhanced: CRC-6, poly x^6+x^4+x^3+1, seed 010101. Input is 24 bits, taken as the bit2,bit3 pair of frames 6..17 in order, then 6 zero augmentation bits. 30 cycles.
  - pend_rdy sets on the final cycle.
- Short frame mapping:
  - bit3 = 1 in frame 0 only.
  - bit2 in frames 0-3 = ID[3:0], frames 4-11 = data[7:0], frames 12-15 = CRC4. All MSB first.
- Enhanced frame mapping:
  - bit3: frames 0-5 = 1, frame 6 = 0, frame 7 = C, frame 12 = 0, frame 17 = 0.
  - bit3 frames 8-11: C=0 → ID[7:4]; C=1 → ID[3:0].
  - bit3 frames 13-16: C=0 → ID[3:0]; C=1 → data[15:12].
  - bit2: frames 0-5 = CRC6[5:0], frames 6-17 = data[11:0]. All MSB first.
- States:
  - IDLE: no active message.
  - SEND: active message, frame_idx_o = current frame.
- Per frame_start_i:
  - If SEND and idx < last: idx++ and present that frame's bits.
  - If SEND and idx == last: pulse msg_done_o, then apply the load rule.
  - If IDLE: apply the load rule.
- Load rule:
  - If pend_rdy: move pending to active, idx = 0, present frame 0 bits, slot frees, state SEND.
  - Otherwise: bit2/bit3 = 0, state IDLE.
- Timing:
  - Bits, idx and msg_done_o are registered and valid the cycle after frame_start_i.
  - Outputs hold between pulses.
- frame_start_i while the pending CRC is still running: treated as not ready. Outputs 0 in IDLE; the message starts on a later pulse.
- Accept and frame_start_i in the same cycle: the accept is latched, and the load rule for that pulse sees the prior pend_rdy.
- A pending message loaded in the same cycle the active one finishes makes msg_ready_o rise the next cycle.
- abort_i: highest priority.
  - Clears both slots and any CRC in progress; state IDLE.
  - Outputs 0 next cycle, no msg_done_o.
  - A simultaneous accept is discarded.
- busy_o = SEND || pending occupied.

Test Plan:
- Reset mid-SEND at frame 7 → all outputs 0 immediately; msg_ready_o = 1 after release with mode_i = 01.
- Short, ID = 0x5, data = 0xA3, 16 frame_start pulses spaced 50 cycles → bit3 1,0×15; bit2 sequence 0101,10100011,CRC4 matching golden model; msg_done_o once after the 16th pulse.
- Enhanced, C = 0, ID = 0x3C, data = 0x0F5 → bit3 111111 0 0 0011 0 1100 0; bit2 = CRC6 then 000011110101; CRC6 matches golden model.
- Enhanced, C = 1, ID = 0x9, data = 0xB0F5 → bit3 frames 8-11 = 1001, frames 13-16 = 1011.
- Second message accepted during the first's frame 3 → frame 0 of message 2 follows the last frame of message 1 directly; msg_done_o pulses twice total.
- frame_start_i 5 cycles after accept (CRC busy) → bits 0, IDLE; message starts on the next pulse. abort_i at enhanced frame 10 → outputs 0, busy_o = 0, no msg_done_o.
